// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter
//   Two-port arbiter in front of a single bootrom. It keeps at most one
//   bootrom transaction in flight and routes each response back to the
//   port that issued the request.
//
//   Arbitration:
//     - If only one port is valid, that port wins.
//     - If both ports are valid, the port not granted last time wins.
//     - After reset, port 0 wins the first tie.
//
//   Optional feature (macro BROM_ARB_TIMEOUT_EN):
//     - Adds a watchdog on the WAIT state.
//     - If the bootrom stays silent for TIMEOUT_CYCLES cycles, the owner
//       gets an error response with zero data.
//     - Without the macro there is no counter, and resp_err is tied low.
//
// Parameters:
//   ADDR_W          request address width
//   DATA_W          response line width
//   TIMEOUT_CYCLES  WAIT watchdog limit (only used with BROM_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   reqN_addr_i / reqN_valid_i    requester address and request pending
//   reqN_ready_o                  request accepted (combinational)
//   reqN_resp_data_o              returned line, held until next response
//   reqN_resp_valid_o             one-cycle response strobe
//   reqN_resp_err_o               timeout error, qualified by resp_valid
//   brom_req_address_o            latched address presented to bootrom
//   brom_req_valid_o              request to bootrom
//   brom_ready_i                  bootrom accepts request
//   brom_resp_data_i / brom_resp_valid_i   bootrom response
module bootrom_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  output logic [DATA_W-1:0] req0_resp_data_o,
  output logic              req0_resp_valid_o,
  output logic              req0_resp_err_o,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  output logic [DATA_W-1:0] req1_resp_data_o,
  output logic              req1_resp_valid_o,
  output logic              req1_resp_err_o,
  output logic [ADDR_W-1:0] brom_req_address_o,
  output logic              brom_req_valid_o,
  input  logic              brom_ready_i,
  input  logic [DATA_W-1:0] brom_resp_data_i,
  input  logic              brom_resp_valid_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic              owner_reg, owner_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  logic [1:0] req_valid;
  logic       winner;
  logic       grant;
  logic       resp_take;
  logic       timeout_fire;

  assign req_valid = {req1_valid_i, req0_valid_i};

  // A tie goes to the port that did not win last time.
  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant_reg;
      default: winner = 1'b0;
    endcase
  end

  // Ready is only ever raised for a port whose valid is high,
  // so any valid input in IDLE is a handshake.
  assign grant        = (state_reg == ST_IDLE) && (|req_valid);
  assign req0_ready_o = grant && !winner;
  assign req1_ready_o = grant && winner;

  assign brom_req_valid_o   = (state_reg == ST_ISSUE);
  assign brom_req_address_o = addr_reg;

  // Responses outside WAIT are stale (e.g. after a reset) and are dropped.
  assign resp_take = (state_reg == ST_WAIT) && brom_resp_valid_i;

`ifdef BROM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == ST_ISSUE && brom_ready_i) begin
      cnt_next = '0;
    end else if (state_reg == ST_WAIT) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // A response arriving in the expiry cycle takes priority over the error.
  assign timeout_fire = (state_reg == ST_WAIT) && !brom_resp_valid_i &&
                        (cnt_reg == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    addr_next       = addr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant) begin
          addr_next       = winner ? req1_addr_i : req0_addr_i;
          owner_next      = winner;
          last_grant_next = winner;
          state_next      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (brom_ready_i) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (resp_take || timeout_fire) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      addr_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      addr_reg       <= addr_next;
    end
  end

  // Per-port response registers.
  // Only the owner's registers move; the other port keeps its last line.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              is_owner;
    logic [DATA_W-1:0] resp_data_reg;
    logic              resp_valid_reg;
    logic              resp_err_reg;

    assign is_owner = (owner_reg == 1'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        resp_data_reg  <= '0;
        resp_valid_reg <= 1'b0;
        resp_err_reg   <= 1'b0;
      end else begin
        resp_valid_reg <= is_owner && (resp_take || timeout_fire);
        resp_err_reg   <= is_owner && timeout_fire;
        if (is_owner && resp_take) begin
          resp_data_reg <= brom_resp_data_i;
        end else if (is_owner && timeout_fire) begin
          resp_data_reg <= '0;
        end
      end
    end
  end

  assign req0_resp_data_o  = g_port[0].resp_data_reg;
  assign req0_resp_valid_o = g_port[0].resp_valid_reg;
  assign req1_resp_data_o  = g_port[1].resp_data_reg;
  assign req1_resp_valid_o = g_port[1].resp_valid_reg;

`ifdef BROM_ARB_TIMEOUT_EN
  assign req0_resp_err_o = g_port[0].resp_err_reg;
  assign req1_resp_err_o = g_port[1].resp_err_reg;
`else
  assign req0_resp_err_o = 1'b0;
  assign req1_resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Self-checking bench for bootrom_arbiter.
//
// Inputs change on the falling edge; outputs are checked on the falling edge
// (or 1 ns after an input change, for the combinational ready).
//
// The reference model tracks only:
//   - the last granted port (alternation rule);
//   - the line each port should currently hold.
module tb_bootrom_arbiter;
  localparam int AW = 24;
  localparam int DW = 128;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] req0_addr, req1_addr;
  logic          req0_valid, req1_valid;
  logic          req0_ready_o, req1_ready_o;
  logic [DW-1:0] req0_resp_data_o, req1_resp_data_o;
  logic          req0_resp_valid_o, req1_resp_valid_o;
  logic          req0_resp_err_o, req1_resp_err_o;
  logic [AW-1:0] brom_req_address_o;
  logic          brom_req_valid_o;
  logic          brom_ready;
  logic [DW-1:0] brom_resp_data;
  logic          brom_resp_valid;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic          m_last;
  logic [DW-1:0] m_data [2];

  bootrom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .rst                (rst),
    .req0_addr_i        (req0_addr),
    .req0_valid_i       (req0_valid),
    .req0_ready_o       (req0_ready_o),
    .req0_resp_data_o   (req0_resp_data_o),
    .req0_resp_valid_o  (req0_resp_valid_o),
    .req0_resp_err_o    (req0_resp_err_o),
    .req1_addr_i        (req1_addr),
    .req1_valid_i       (req1_valid),
    .req1_ready_o       (req1_ready_o),
    .req1_resp_data_o   (req1_resp_data_o),
    .req1_resp_valid_o  (req1_resp_valid_o),
    .req1_resp_err_o    (req1_resp_err_o),
    .brom_req_address_o (brom_req_address_o),
    .brom_req_valid_o   (brom_req_valid_o),
    .brom_ready_i       (brom_ready),
    .brom_resp_data_i   (brom_resp_data),
    .brom_resp_valid_i  (brom_resp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic get_rv(input int p);
    return (p == 1) ? req1_resp_valid_o : req0_resp_valid_o;
  endfunction

  function automatic logic get_err(input int p);
    return (p == 1) ? req1_resp_err_o : req0_resp_err_o;
  endfunction

  function automatic logic [DW-1:0] get_data(input int p);
    return (p == 1) ? req1_resp_data_o : req0_resp_data_o;
  endfunction

  // Advance n cycles, expecting no bootrom request and no responses.
  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("quiet_rv0", req0_resp_valid_o, 1'b0);
      chk("quiet_rv1", req1_resp_valid_o, 1'b0);
      chk("quiet_brom_valid", brom_req_valid_o, 1'b0);
    end
  endtask

  // One full transaction.
  //   rd    : cycles brom_ready is held low while in ISSUE
  //   dly   : idle cycles in WAIT before the response
  //   poke  : pulse req1_valid for one cycle while waiting
  task automatic do_txn(input logic v0, input logic v1, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input int rd, input int dly,
                        input logic [DW-1:0] d, input bit poke);
    logic          w;
    logic [AW-1:0] ea;
    int            wi;
    w  = (v0 && v1) ? ~m_last : v1;
    ea = w ? a1 : a0;
    wi = w ? 1 : 0;

    req0_valid = v0; req1_valid = v1; req0_addr = a0; req1_addr = a1;
    #1;
    chk("ready0", req0_ready_o, !w);
    chk("ready1", req1_ready_o, w);
    chk("brom_valid_idle", brom_req_valid_o, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rv0_low_issue", req0_resp_valid_o, 1'b0);
    chk("rv1_low_issue", req1_resp_valid_o, 1'b0);

    for (int i = 0; i < rd; i++) begin
      chk("brom_valid_hold", brom_req_valid_o, 1'b1);
      chk("brom_addr_hold", brom_req_address_o, ea);
      tick();
    end
    chk("brom_valid", brom_req_valid_o, 1'b1);
    chk("brom_addr", brom_req_address_o, ea);
    brom_ready = 1'b1;
    tick();
    brom_ready = 1'b0;
    chk("brom_valid_wait", brom_req_valid_o, 1'b0);

    for (int i = 0; i < dly; i++) begin
      if (poke && i == 0) begin
        req1_valid = 1'b1;
        #1;
        chk("poke_ready1", req1_ready_o, 1'b0);
        chk("poke_ready0", req0_ready_o, 1'b0);
      end
      tick();
      req1_valid = 1'b0;
    end

    brom_resp_valid = 1'b1; brom_resp_data = d;
    tick();
    brom_resp_valid = 1'b0; brom_resp_data = {4{$urandom}};

    chk("resp_valid_owner", get_rv(wi), 1'b1);
    chk("resp_data_owner", get_data(wi), d);
    chk("resp_err_owner", get_err(wi), 1'b0);
    chk("resp_valid_other", get_rv(1 - wi), 1'b0);
    chk("resp_data_other", get_data(1 - wi), m_data[1 - wi]);
    m_data[wi] = d;
    m_last = w;
    $display("txn owner=%0d addr=%06h data=%032h", wi, ea, d);
  endtask

  initial begin
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    m_last = 1'b1; m_data[0] = '0; m_data[1] = '0;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
    brom_ready = 0; brom_resp_valid = 0; brom_resp_data = '0;

    @(negedge clk);
    chk("rst_brom_valid", brom_req_valid_o, 1'b0);
    chk("rst_brom_addr", brom_req_address_o, '0);
    chk("rst_rv0", req0_resp_valid_o, 1'b0);
    chk("rst_rv1", req1_resp_valid_o, 1'b0);
    chk("rst_err0", req0_resp_err_o, 1'b0);
    chk("rst_err1", req1_resp_err_o, 1'b0);
    chk("rst_data0", req0_resp_data_o, '0);
    chk("rst_data1", req1_resp_data_o, '0);
    req0_valid = 1; req1_valid = 1;
    tick();
    rst = 1'b0;

    // Both valid at reset release: port 0 first, then alternating rounds.
    for (int r = 0; r < 4; r++) begin
      do_txn(1, 1, 24'h001000 + 24'(r), 24'h002000 + 24'(r), 0, 1, {4{$urandom}}, 0);
      do_txn(0, 1, 24'h0, 24'h002000 + 24'(r), 0, 1, {4{$urandom}}, 0);
    end
    quiet(1);

    // Single request; the bootrom answers 4 cycles after accept.
    do_txn(1, 0, 24'h000100, 24'h0, 0, 3, a5, 0);
    quiet(1);

    // Bootrom stalls 10 cycles in ISSUE.
    do_txn(1, 0, 24'h000200, 24'h0, 10, 0, {4{$urandom}}, 0);
    quiet(1);

    // req1 pokes while req0 owns the transaction, then drops.
    do_txn(1, 0, 24'h000300, 24'h0, 1, 3, {4{$urandom}}, 1);
    quiet(4);

    // Reset in WAIT; the late response must be discarded.
    req0_valid = 1; req0_addr = 24'h000500;
    tick();
    req0_valid = 0; brom_ready = 1;
    tick();
    brom_ready = 0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_brom_valid", brom_req_valid_o, 1'b0);
    chk("midrst_brom_addr", brom_req_address_o, '0);
    chk("midrst_data0", req0_resp_data_o, '0);
    tick();
    rst = 1'b0;
    m_last = 1'b1; m_data[0] = '0; m_data[1] = '0;
    tick();
    tick();
    brom_resp_valid = 1; brom_resp_data = a5;
    tick();
    brom_resp_valid = 0;
    chk("late_rv0", req0_resp_valid_o, 1'b0);
    chk("late_rv1", req1_resp_valid_o, 1'b0);
    quiet(3);
    do_txn(1, 1, 24'h000600, 24'h000700, 0, 0, {4{$urandom}}, 0);
    quiet(1);

`ifdef BROM_ARB_TIMEOUT_EN
    // Silent bootrom: the error strobe appears 9 cycles after WAIT entry.
    req1_valid = 1; req1_addr = 24'h000400;
    tick();
    req1_valid = 0; brom_ready = 1;
    tick();
    brom_ready = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      chk("to_early_rv1", req1_resp_valid_o, 1'b0);
    end
    tick();
    chk("to_rv1", req1_resp_valid_o, 1'b1);
    chk("to_err1", req1_resp_err_o, 1'b1);
    chk("to_data1", req1_resp_data_o, '0);
    chk("to_rv0", req0_resp_valid_o, 1'b0);
    m_data[1] = '0; m_last = 1'b1;
    $display("timeout owner=1 addr=000400");
    brom_resp_valid = 1; brom_resp_data = a5;
    tick();
    brom_resp_valid = 0;
    chk("to_late_rv1", req1_resp_valid_o, 1'b0);
    chk("to_late_data1", req1_resp_data_o, '0);
    quiet(2);
`endif

    // Randomised traffic against the model.
    for (int n = 0; n < 24; n++) begin
      int unsigned pat;
      pat = $urandom_range(1, 3);
      do_txn(pat[0], pat[1], AW'($urandom), AW'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)), {$urandom, $urandom, $urandom, $urandom}, 0);
      if ($urandom_range(0, 1) == 1) quiet(1);
    end
    quiet(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
